// File: rtl/windower_stride.sv
// Streaming 1D sliding-window generator: zero-pads both frame edges, emits one
// WINDOW-wide vector per stride step, valid/ready flow control on both sides.
module windower_stride #(
    parameter int unsigned NO_CH         = 16,
    parameter int unsigned LOG2_IMG_SIZE = 6,
    parameter int unsigned WINDOW        = 3,
    parameter int unsigned PADDING       = 1,
    parameter int unsigned STRIDE        = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_in,
    input  logic [NO_CH-1:0]              data_in,
    output logic                          vld_out,
    input  logic                          rdy_out,
    output logic [WINDOW-1:0][NO_CH-1:0]  data_out,
    output logic                          first_out,
    output logic                          last_out
);
    localparam int unsigned IMG    = 1 << LOG2_IMG_SIZE;
    localparam int unsigned PADDED = IMG + 2 * PADDING;
    localparam int unsigned N_OUT  = (PADDED - WINDOW) / STRIDE + 1;
    localparam int unsigned PCW    = LOG2_IMG_SIZE + 2;
    localparam int unsigned LAST_L = (PADDING == 0) ? 0 : PADDING - 1;
    localparam int unsigned LAST_D = PADDING + IMG - 1;
    localparam int unsigned LAST_R = PADDED - 1;

    typedef enum logic [1:0] {
        PAD_L = 2'd0,
        DATA  = 2'd1,
        PAD_R = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [PCW-1:0]                 pc;
    logic [PCW-1:0]                 win_start;
    logic [PCW-1:0]                 win_cnt;
    logic [WINDOW-1:0][NO_CH-1:0]   taps;
    logic [WINDOW-1:0][NO_CH-1:0]   taps_nxt;
    logic                           can_shift;
    logic                           shift;
    logic                           push_zero;
    logic                           frame_end;
    logic                           win_done;

    assign can_shift = !vld_out || rdy_out;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PAD_L;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; frame_end marks the shift that pushes the final padded element
    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        unique case (state)
            PAD_L: begin
                if (PADDING == 0) begin
                    state_nxt = DATA;
                end else if (shift && pc == PCW'(LAST_L)) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (shift && pc == PCW'(LAST_D)) begin
                    if (PADDING == 0) begin
                        frame_end = 1'b1;
                    end else begin
                        state_nxt = PAD_R;
                    end
                end
            end
            PAD_R: begin
                if (shift && pc == PCW'(LAST_R)) begin
                    state_nxt = PAD_L;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = PAD_L;
        endcase
    end

    // State-decoded controls: padding states push zeros without consuming input
    always_comb begin
        rdy_in    = 1'b0;
        shift     = 1'b0;
        push_zero = 1'b1;
        unique case (state)
            PAD_L: shift = can_shift && (PADDING != 0);
            DATA: begin
                rdy_in    = can_shift;
                shift     = can_shift && vld_in;
                push_zero = 1'b0;
            end
            PAD_R:   shift = can_shift;
            default: shift = 1'b0;
        endcase
    end

    // Shifted tap image and window-completion detect for the current push
    always_comb begin
        taps_nxt = taps;
        for (int t = 0; t < int'(WINDOW) - 1; t++) begin
            taps_nxt[t] = taps[t+1];
        end
        taps_nxt[WINDOW-1] = push_zero ? '0 : data_in;
    end

    assign win_done = (pc == win_start + PCW'(WINDOW - 1)) && (win_cnt < PCW'(N_OUT));

    // Shift register, padded-index counter and window bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps      <= '0;
            pc        <= '0;
            win_start <= '0;
            win_cnt   <= '0;
        end else if (shift) begin
            taps <= taps_nxt;
            if (frame_end) begin
                pc        <= '0;
                win_start <= '0;
                win_cnt   <= '0;
            end else begin
                pc <= pc + 1'b1;
                if (win_done) begin
                    win_cnt <= win_cnt + 1'b1;
                    if (win_cnt != PCW'(N_OUT - 1)) begin
                        win_start <= win_start + PCW'(STRIDE);
                    end
                end
            end
        end
    end

    // Output register: a completing shift only happens when the slot is free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_out   <= 1'b0;
            data_out  <= '0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (shift && win_done) begin
            vld_out   <= 1'b1;
            data_out  <= taps_nxt;
            first_out <= (win_cnt == '0);
            last_out  <= (win_cnt == PCW'(N_OUT - 1));
        end else if (rdy_out) begin
            vld_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_windower_stride.sv
// Scoreboard bench for windower_stride: default, stride-2 and no-padding
// instances, back-pressure, back-to-back frames and mid-frame reset.
module tb_windower_stride;
    localparam int unsigned NO_CH = 16;
    localparam int unsigned W     = 3;

    typedef logic [W-1:0][NO_CH-1:0] vec_t;
    typedef struct packed {
        logic [1:0] inst;
        vec_t       d;
        logic       first;
        logic       last;
    } win_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld_in;
    logic [15:0] data_in;
    logic        rdy_out;
    logic [1:0]  sel;
    logic        bp_en;
    logic        sb_en;
    logic [2:0]  vo, fo, lo, ri;
    vec_t        dout [3];
    logic        rdy_sel;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    win_t   exp_q [$];
    vec_t   act_d [$];
    int     act_c [$];
    logic        held = 1'b0;
    logic [49:0] hold_w;

    always #5 clk = ~clk;

    windower_stride u_main (
        .clk(clk), .rst(rst), .vld_in(vld_in && sel == 2'd0), .rdy_in(ri[0]),
        .data_in(data_in), .vld_out(vo[0]), .rdy_out(rdy_out), .data_out(dout[0]),
        .first_out(fo[0]), .last_out(lo[0])
    );

    windower_stride #(.STRIDE(2)) u_s2 (
        .clk(clk), .rst(rst), .vld_in(vld_in && sel == 2'd1), .rdy_in(ri[1]),
        .data_in(data_in), .vld_out(vo[1]), .rdy_out(1'b1), .data_out(dout[1]),
        .first_out(fo[1]), .last_out(lo[1])
    );

    windower_stride #(.PADDING(0)) u_p0 (
        .clk(clk), .rst(rst), .vld_in(vld_in && sel == 2'd2), .rdy_in(ri[2]),
        .data_in(data_in), .vld_out(vo[2]), .rdy_out(1'b1), .data_out(dout[2]),
        .first_out(fo[2]), .last_out(lo[2])
    );

    assign rdy_sel = (sel == 2'd0) ? ri[0] : (sel == 2'd1) ? ri[1] : ri[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mkw(input int a0, input int a1, input int a2);
        vec_t v;
        v[0] = 16'(a0);
        v[1] = 16'(a1);
        v[2] = 16'(a2);
        return v;
    endfunction

    function automatic logic [63:0] w64(input vec_t v);
        return {16'd0, v};
    endfunction

    function automatic vec_t get_d(input int i);
        vec_t v;
        v = '0;
        if (i < act_d.size()) v = act_d[i];
        return v;
    endfunction

    function automatic int get_c(input int i);
        int c;
        c = -1000;
        if (i < act_c.size()) c = act_c[i];
        return c;
    endfunction

    // Expected windows of one frame straight from the padded-stream definition
    task automatic push_frame(input logic [1:0] inst, input int base, input int pad, input int stride);
        int padded;
        int nout;
        padded = 64 + 2 * pad;
        nout   = (padded - int'(W)) / stride + 1;
        for (int k = 0; k < nout; k++) begin
            win_t w;
            w.inst  = inst;
            w.first = (k == 0);
            w.last  = (k == nout - 1);
            for (int t = 0; t < int'(W); t++) begin
                int j;
                j = k * stride + t;
                w.d[t] = (j >= pad && j < 64 + pad) ? 16'(base + j - pad) : 16'd0;
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic send_frame(input int base, input int n, output int low_before);
        low_before = 0;
        for (int i = 0; i < n; i++) begin
            int guard;
            guard   = 0;
            vld_in  = 1'b1;
            data_in = 16'(base + i);
            @(negedge clk);
            while (!rdy_sel) begin
                if (i == 0) low_before++;
                guard++;
                if (guard > 500) begin
                    n_errors++;
                    $display("FAIL send_timeout sample=%0d rdy_in=0 required=1", i);
                    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
                    $fatal(1, "input handshake timeout");
                end
                @(negedge clk);
            end
            @(posedge clk);
            #1;
        end
        vld_in = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic clear_act();
        act_d.delete();
        act_c.delete();
    endtask

    // Downstream ready: random when back-pressure is enabled
    initial begin
        rdy_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_out = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pop and compare on every output handshake, check stall behaviour
    always @(negedge clk) begin
        win_t a;
        win_t e;
        cyc++;
        if (rst && sb_en) begin
            for (int i = 0; i < 3; i++) begin
                if (vo[i] && ((i != 0) || rdy_out)) begin
                    a.inst  = 2'(i);
                    a.d     = dout[i];
                    a.first = fo[i];
                    a.last  = lo[i];
                    act_d.push_back(dout[i]);
                    act_c.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_window inst=%0d data=%h expected=none", i, dout[i]);
                    end else begin
                        e = exp_q.pop_front();
                        check("window", {12'd0, a}, {12'd0, e});
                    end
                end
            end
            if (held) begin
                check("bp_hold", {13'd0, vo[0], fo[0], lo[0], dout[0]}, {13'd0, 1'b1, hold_w});
            end
            if (vo[0] && !rdy_out) begin
                check("bp_rdy_in", 64'(ri[0]), 64'(0));
                held   = 1'b1;
                hold_w = {fo[0], lo[0], dout[0]};
            end else begin
                held = 1'b0;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t limit=500000", $time);
        $display("CHECKS %0d ERRORS %0d", n_checks + 1, n_errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int l1;
        int l2;
        rst     = 1'b0;
        vld_in  = 1'b0;
        data_in = '0;
        sel     = 2'd0;
        bp_en   = 1'b0;
        sb_en   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy_in", 64'(ri[0]), 64'(0));
        check("rst_vld_out", 64'(vo[0]), 64'(0));
        check("rst_data_out", w64(dout[0]), 64'(0));
        check("rst_flags", 64'({fo[0], lo[0]}), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Defaults, full throughput
        clear_act();
        push_frame(2'd0, 1024, 1, 1);
        send_frame(1024, 64, l1);
        wait_drain();
        check("t1_count", 64'(act_d.size()), 64'(64));
        check("t1_first", w64(get_d(0)), w64(mkw(0, 1024, 1025)));
        check("t1_second", w64(get_d(1)), w64(mkw(1024, 1025, 1026)));
        check("t1_last", w64(get_d(63)), w64(mkw(1086, 1087, 0)));
        check("t1_consecutive", 64'(get_c(63) - get_c(0)), 64'(63));

        // Random downstream back-pressure
        bp_en = 1'b1;
        clear_act();
        push_frame(2'd0, 1024, 1, 1);
        send_frame(1024, 64, l1);
        wait_drain();
        bp_en = 1'b0;
        check("bp_count", 64'(act_d.size()), 64'(64));
        check("bp_last", w64(get_d(63)), w64(mkw(1086, 1087, 0)));
        repeat (3) @(posedge clk);
        #1;

        // Two frames back-to-back
        clear_act();
        push_frame(2'd0, 1024, 1, 1);
        push_frame(2'd0, 2048, 1, 1);
        send_frame(1024, 64, l1);
        send_frame(2048, 64, l2);
        wait_drain();
        check("b2b_count", 64'(act_d.size()), 64'(128));
        check("b2b_gap", 64'(l2), 64'(2));
        check("b2b_f2_first", w64(get_d(64)), w64(mkw(0, 2048, 2049)));
        check("b2b_f2_second", w64(get_d(65)), w64(mkw(2048, 2049, 2050)));

        // Reset in the middle of a frame
        sb_en = 1'b0;
        send_frame(1024, 21, l1);
        rst = 1'b0;
        #1;
        check("mrst_vld_out", 64'(vo[0]), 64'(0));
        check("mrst_data_out", w64(dout[0]), 64'(0));
        check("mrst_flags", 64'({fo[0], lo[0]}), 64'(0));
        @(negedge clk);
        check("mrst_rdy_in", 64'(ri[0]), 64'(0));
        check("mrst_vld_hold", 64'(vo[0]), 64'(0));
        rst = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        @(posedge clk);
        #1;
        clear_act();
        push_frame(2'd0, 1024, 1, 1);
        send_frame(1024, 64, l1);
        wait_drain();
        check("mrst_count", 64'(act_d.size()), 64'(64));
        check("mrst_first", w64(get_d(0)), w64(mkw(0, 1024, 1025)));
        check("mrst_last", w64(get_d(63)), w64(mkw(1086, 1087, 0)));
        check("mrst_consecutive", 64'(get_c(63) - get_c(0)), 64'(63));

        // STRIDE = 2
        sel = 2'd1;
        clear_act();
        push_frame(2'd1, 1024, 1, 2);
        send_frame(1024, 64, l1);
        wait_drain();
        check("s2_count", 64'(act_d.size()), 64'(32));
        check("s2_first", w64(get_d(0)), w64(mkw(0, 1024, 1025)));
        check("s2_second", w64(get_d(1)), w64(mkw(1025, 1026, 1027)));
        check("s2_last", w64(get_d(31)), w64(mkw(1085, 1086, 1087)));
        check("s2_cadence", 64'(get_c(1) - get_c(0)), 64'(2));
        check("s2_span", 64'(get_c(31) - get_c(0)), 64'(62));

        // PADDING = 0, two frames with no gap
        sel = 2'd2;
        clear_act();
        push_frame(2'd2, 1024, 0, 1);
        push_frame(2'd2, 2048, 0, 1);
        send_frame(1024, 64, l1);
        send_frame(2048, 64, l2);
        wait_drain();
        check("p0_count", 64'(act_d.size()), 64'(124));
        check("p0_first", w64(get_d(0)), w64(mkw(1024, 1025, 1026)));
        check("p0_last", w64(get_d(61)), w64(mkw(1085, 1086, 1087)));
        check("p0_f2_first", w64(get_d(62)), w64(mkw(2048, 2049, 2050)));
        check("p0_gap", 64'(l2), 64'(0));
        check("p0_frame_span", 64'(get_c(62) - get_c(0)), 64'(64));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
